// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Groups every handshake and bus signal of the memory bus arbiter.
//   Fetch port : if_ce_i, if_addr_i -> if_data_o, if_ready_o
//   Data port  : mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i -> mem_data_o, mem_ready_o
//   Pipeline   : stall_o
//   SRAM bus   : bus_ce_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o <- bus_data_i
// The slave modport is the arbiter's view; master is the core + SRAM side.
interface mem_bus_arbiter_if;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;

  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;

  logic        stall_o;

  logic        bus_ce_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;

  modport slave (
    input  if_ce_i, if_addr_i,
    output if_data_o, if_ready_o,
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ready_o,
    output stall_o,
    output bus_ce_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o,
    input  bus_data_i
  );

  modport master (
    output if_ce_i, if_addr_i,
    input  if_data_o, if_ready_o,
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ready_o,
    input  stall_o,
    input  bus_ce_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o,
    output bus_data_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-ported multi-cycle SRAM bus between the instruction
// fetch port and the data port. Data has fixed priority over fetch. Each
// access is latched into bus registers, held for WAIT_CYCLES cycles, and
// completed with a one-cycle ready pulse on the granted port.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   io   - mem_bus_arbiter_if.slave (fetch, data, stall and SRAM bus signals)
// WAIT_CYCLES must lie in 1..15 (the wait counter is 4 bits wide).
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   io
);

  typedef enum logic [1:0] {
    IDLE,
    DATA_ACC,
    INST_ACC
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busCe_q, busCe_d;
  logic        busWe_q, busWe_d;
  logic [31:0] busAddr_q, busAddr_d;
  logic [3:0]  busSel_q, busSel_d;
  logic [31:0] busWdata_q, busWdata_d;
  logic [31:0] ifData_q, ifData_d;
  logic        ifReady_q, ifReady_d;
  logic [31:0] memData_q, memData_d;
  logic        memReady_q, memReady_d;

  logic dataElig;
  logic instElig;

  // A port whose ready is high this cycle still shows its old request;
  // masking it prevents granting the same access twice.
  assign dataElig = io.mem_ce_i & ~memReady_q;
  assign instElig = io.if_ce_i  & ~ifReady_q;

  // Next-state logic: grant in IDLE, count down in the access states and
  // complete when the counter reaches zero. Bus registers are cleared on
  // completion so the bus reads all-zero whenever the FSM is idle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busCe_d    = busCe_q;
    busWe_d    = busWe_q;
    busAddr_d  = busAddr_q;
    busSel_d   = busSel_q;
    busWdata_d = busWdata_q;
    ifData_d   = ifData_q;
    memData_d  = memData_q;
    ifReady_d  = 1'b0;
    memReady_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (dataElig) begin
          state_d    = DATA_ACC;
          cnt_d      = CNT_LOAD;
          busCe_d    = 1'b1;
          busWe_d    = io.mem_we_i;
          busAddr_d  = io.mem_addr_i;
          busSel_d   = io.mem_sel_i;
          busWdata_d = io.mem_data_i;
        end else if (instElig) begin
          state_d    = INST_ACC;
          cnt_d      = CNT_LOAD;
          busCe_d    = 1'b1;
          busWe_d    = 1'b0;
          busAddr_d  = io.if_addr_i;
          busSel_d   = 4'b1111;
          busWdata_d = 32'd0;
        end
      end

      DATA_ACC, INST_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d    = IDLE;
          busCe_d    = 1'b0;
          busWe_d    = 1'b0;
          busAddr_d  = 32'd0;
          busSel_d   = 4'd0;
          busWdata_d = 32'd0;
          if (state_q == DATA_ACC) begin
            memData_d  = busWe_q ? 32'd0 : io.bus_data_i;
            memReady_d = 1'b1;
          end else begin
            ifData_d  = io.bus_data_i;
            ifReady_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      busCe_q    <= 1'b0;
      busWe_q    <= 1'b0;
      busAddr_q  <= 32'd0;
      busSel_q   <= 4'd0;
      busWdata_q <= 32'd0;
      ifData_q   <= 32'd0;
      ifReady_q  <= 1'b0;
      memData_q  <= 32'd0;
      memReady_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busCe_q    <= busCe_d;
      busWe_q    <= busWe_d;
      busAddr_q  <= busAddr_d;
      busSel_q   <= busSel_d;
      busWdata_q <= busWdata_d;
      ifData_q   <= ifData_d;
      ifReady_q  <= ifReady_d;
      memData_q  <= memData_d;
      memReady_q <= memReady_d;
    end
  end

  assign io.bus_ce_o    = busCe_q;
  assign io.bus_we_o    = busWe_q;
  assign io.bus_addr_o  = busAddr_q;
  assign io.bus_sel_o   = busSel_q;
  assign io.bus_data_o  = busWdata_q;
  assign io.if_data_o   = ifData_q;
  assign io.if_ready_o  = ifReady_q;
  assign io.mem_data_o  = memData_q;
  assign io.mem_ready_o = memReady_q;

  // Stall is combinational so the pipeline freezes in the same cycle a
  // request appears and releases in the ready cycle.
  assign io.stall_o = (io.if_ce_i & ~ifReady_q) | (io.mem_ce_i & ~memReady_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Scoreboard bench: each request pushes its expected bus access and its
// expected read data; a negedge monitor pops and compares them when the
// bus access starts and when the port's ready pulse appears.
module tb_mem_bus_arbiter;
  localparam int W = 2;
  localparam int FETCH = 0;
  localparam int LOAD  = 1;
  localparam int STORE = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } busExp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_bus_arbiter_if io();

  mem_bus_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  // Clock generation
  always #5 clk = ~clk;

  // SRAM model: fixed word for 0x100, otherwise an address-derived pattern
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h3C01_0001;
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign io.bus_data_i = memWord(io.bus_addr_o);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busStarts = 0;
  int lastBusStart = 0;
  int lastIfReady = 0;
  int lastMemReady = 0;
  int ifReadyCnt = 0;
  int memReadyCnt = 0;
  logic busCePrev = 1'b0;
  logic ifRdyPrev = 1'b0;
  logic memRdyPrev = 1'b0;
  busExp_t curExp;

  busExp_t     busQ[$];
  logic [31:0] ifQ[$];
  logic [31:0] memQ[$];

  // Cycle counter: cycle N spans posedge N to posedge N+1
  always @(posedge clk) cyc++;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request onto a port and record what it should produce
  task automatic applyStimulus(input int kind, input logic [31:0] addr,
                               input logic [3:0] sel, input logic [31:0] data);
    busExp_t e;
    if (kind == FETCH) begin
      io.if_ce_i   = 1'b1;
      io.if_addr_i = addr;
      e = '{we: 1'b0, addr: addr, sel: 4'hF, data: 32'd0};
      ifQ.push_back(memWord(addr));
    end else begin
      io.mem_ce_i   = 1'b1;
      io.mem_we_i   = (kind == STORE);
      io.mem_addr_i = addr;
      io.mem_sel_i  = sel;
      io.mem_data_i = data;
      e = '{we: (kind == STORE), addr: addr, sel: sel, data: data};
      memQ.push_back((kind == STORE) ? 32'd0 : memWord(addr));
    end
    busQ.push_back(e);
  endtask

  task automatic cycleStart();
    @(posedge clk);
    #1;
  endtask

  // Run until the requested number of ready pulses is seen (bounded);
  // optionally withdraw each request the cycle after its ready pulse.
  task automatic runUntil(input int ifN, input int memN, input bit autoDrop);
    int ifSeen = 0;
    int memSeen = 0;
    bit dropIf = 1'b0;
    bit dropMem = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) begin
        cycleStart();
        if (dropIf)  begin io.if_ce_i  = 1'b0; dropIf  = 1'b0; end
        if (dropMem) begin io.mem_ce_i = 1'b0; dropMem = 1'b0; end
      end
      @(negedge clk);
      if (io.if_ready_o)  begin ifSeen++;  dropIf  = autoDrop; end
      if (io.mem_ready_o) begin memSeen++; dropMem = autoDrop; end
      if (ifSeen >= ifN && memSeen >= memN) break;
    end
    cycleStart();
    if (dropIf)  io.if_ce_i  = 1'b0;
    if (dropMem) io.mem_ce_i = 1'b0;
    checkOutput("readyCount", {32'(ifSeen), 32'(memSeen)}, {32'(ifN), 32'(memN)});
  endtask

  // Monitor: bus accesses and ready pulses against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      busCePrev  = 1'b0;
      ifRdyPrev  = 1'b0;
      memRdyPrev = 1'b0;
    end else begin
      if (io.bus_ce_o && !busCePrev) begin
        busStarts++;
        lastBusStart = cyc;
        checkOutput("busQueued", 64'(busQ.size() != 0), 64'd1);
        if (busQ.size() != 0) begin
          curExp = busQ.pop_front();
          checkOutput("busAddr", 64'(io.bus_addr_o), 64'(curExp.addr));
          checkOutput("busWe", 64'(io.bus_we_o), 64'(curExp.we));
          checkOutput("busSel", 64'(io.bus_sel_o), 64'(curExp.sel));
          if (curExp.we) checkOutput("busData", 64'(io.bus_data_o), 64'(curExp.data));
        end
      end else if (io.bus_ce_o) begin
        checkOutput("busStable", 64'({io.bus_we_o, io.bus_sel_o, io.bus_addr_o}),
                    64'({curExp.we, curExp.sel, curExp.addr}));
      end else begin
        if (busCePrev) checkOutput("busLen", 64'(cyc - lastBusStart), 64'(W));
        checkOutput("busIdleCtl", 64'({io.bus_we_o, io.bus_sel_o, io.bus_addr_o}), 64'd0);
        checkOutput("busIdleData", 64'(io.bus_data_o), 64'd0);
      end
      busCePrev = io.bus_ce_o;

      if (io.if_ready_o) begin
        checkOutput("ifPulse", 64'(ifRdyPrev), 64'd0);
        lastIfReady = cyc;
        ifReadyCnt++;
        checkOutput("ifQueued", 64'(ifQ.size() != 0), 64'd1);
        if (ifQ.size() != 0) checkOutput("ifData", 64'(io.if_data_o), 64'(ifQ.pop_front()));
      end
      ifRdyPrev = io.if_ready_o;

      if (io.mem_ready_o) begin
        checkOutput("memPulse", 64'(memRdyPrev), 64'd0);
        lastMemReady = cyc;
        memReadyCnt++;
        checkOutput("memQueued", 64'(memQ.size() != 0), 64'd1);
        if (memQ.size() != 0) checkOutput("memData", 64'(io.mem_data_o), 64'(memQ.pop_front()));
      end
      memRdyPrev = io.mem_ready_o;
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int startsBefore;
    int memBefore;

    io.if_ce_i    = 1'b0;
    io.if_addr_i  = 32'd0;
    io.mem_ce_i   = 1'b0;
    io.mem_we_i   = 1'b0;
    io.mem_addr_i = 32'd0;
    io.mem_sel_i  = 4'd0;
    io.mem_data_i = 32'd0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rstBusCtl", 64'({io.bus_ce_o, io.bus_we_o, io.bus_sel_o, io.bus_addr_o}), 64'd0);
    checkOutput("rstBusData", 64'(io.bus_data_o), 64'd0);
    checkOutput("rstReady", 64'({io.if_ready_o, io.mem_ready_o}), 64'd0);
    checkOutput("rstIfData", 64'(io.if_data_o), 64'd0);
    checkOutput("rstMemData", 64'(io.mem_data_o), 64'd0);
    checkOutput("rstStall", 64'(io.stall_o), 64'd0);
    cycleStart();
    rst = 1'b1;
    cycleStart();

    // Single fetch, cycle-by-cycle against the latency table
    applyStimulus(FETCH, 32'h0000_0100, 4'h0, 32'd0);
    for (int c = 0; c <= W + 1; c++) begin
      if (c > 0) cycleStart();
      @(negedge clk);
      checkOutput("t1BusCe", 64'(io.bus_ce_o), 64'(c >= 1 && c <= W));
      checkOutput("t1Ready", 64'(io.if_ready_o), 64'(c == W + 1));
      checkOutput("t1Stall", 64'(io.stall_o), 64'(c <= W));
      if (c == W + 1) checkOutput("t1IfData", 64'(io.if_data_o), 64'h3C01_0001);
    end
    cycleStart();
    io.if_ce_i = 1'b0;
    repeat (2) cycleStart();

    // Simultaneous fetch and load: data wins, fetch follows
    applyStimulus(LOAD, 32'h0000_2000, 4'hF, 32'h1111_2222);
    applyStimulus(FETCH, 32'h0000_0104, 4'h0, 32'd0);
    t0 = cyc;
    runUntil(1, 1, 1'b1);
    checkOutput("t2MemLat", 64'(lastMemReady - t0), 64'(W + 1));
    checkOutput("t2IfLat", 64'(lastIfReady - t0), 64'(2 * W + 2));
    checkOutput("t2FetchBus", 64'(lastBusStart - t0), 64'(W + 2));
    repeat (2) cycleStart();

    // Store: write data on the bus, mem_data_o reads back 0
    applyStimulus(STORE, 32'h0000_2000, 4'b0011, 32'hDEAD_BEEF);
    t0 = cyc;
    runUntil(0, 1, 1'b1);
    checkOutput("t3MemLat", 64'(lastMemReady - t0), 64'(W + 1));
    checkOutput("t3MemHold", 64'(io.mem_data_o), 64'd0);
    checkOutput("t3IfHold", 64'(io.if_data_o), 64'(memWord(32'h0000_0104)));
    repeat (2) cycleStart();

    // Back-to-back fetches with if_ce_i held high
    startsBefore = busStarts;
    applyStimulus(FETCH, 32'h0000_0100, 4'h0, 32'd0);
    t0 = cyc;
    runUntil(1, 0, 1'b0);
    applyStimulus(FETCH, 32'h0000_0104, 4'h0, 32'd0);
    runUntil(1, 0, 1'b1);
    checkOutput("t4SecondStart", 64'(lastBusStart - t0), 64'(W + 3));
    repeat (3) cycleStart();
    checkOutput("t4Accesses", 64'(busStarts - startsBefore), 64'd2);

    // Fetch withdrawn in cycle 1 still completes, no retry
    startsBefore = busStarts;
    applyStimulus(FETCH, 32'h0000_0108, 4'h0, 32'd0);
    t0 = cyc;
    cycleStart();
    io.if_ce_i = 1'b0;
    runUntil(1, 0, 1'b1);
    checkOutput("t5IfLat", 64'(lastIfReady - t0), 64'(W + 1));
    repeat (6) cycleStart();
    checkOutput("t5Accesses", 64'(busStarts - startsBefore), 64'd1);

    // Reset in cycle 1 of a store, request held through reset
    applyStimulus(STORE, 32'h0000_3000, 4'hC, 32'h1234_5678);
    cycleStart();
    checkOutput("t6CeBefore", 64'(io.bus_ce_o), 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("t6CeDrop", 64'(io.bus_ce_o), 64'd0);
    memBefore = memReadyCnt;
    repeat (2) begin
      @(negedge clk);
      checkOutput("t6NoReady", 64'(io.mem_ready_o), 64'd0);
      checkOutput("t6Stall", 64'(io.stall_o), 64'd1);
      cycleStart();
    end
    checkOutput("t6NoPulse", 64'(memReadyCnt - memBefore), 64'd0);
    rst = 1'b1;
    t0 = cyc;
    runUntil(0, 1, 1'b1);
    checkOutput("t6RestartLat", 64'(lastMemReady - t0), 64'(W + 1));

    repeat (3) cycleStart();
    checkOutput("queuesEmpty", 64'(busQ.size() + ifQ.size() + memQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbiter/sequencer that shares one single-ported, multi-cycle external memory bus between the CPU's instruction-fetch port and its data (load/store) port. It sits between the `mips` core's `rom_*`/`mem_*` ports and the external SRAM bus. Each access is latched, sequenced for a fixed number of wait cycles, and completed with a one-cycle ready pulse. It also raises a pipeline stall request while any request is outstanding.

## Interface
- WAIT_CYCLES, 2: cycles the bus holds `bus_ce_o` per access; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_ce_i  in  1  fetch request; held until `if_ready_o`.
- if_addr_i  in  32  fetch address.
- if_data_o  out  32  fetched instruction, valid while `if_ready_o`=1.
- if_ready_o  out  1  one-cycle fetch completion pulse.
- mem_ce_i  in  1  data request; held until `mem_ready_o`.
- mem_we_i  in  1  1=store, 0=load.
- mem_addr_i  in  32  data address.
- mem_sel_i  in  4  byte enables.
- mem_data_i  in  32  store data.
- mem_data_o  out  32  load data, valid while `mem_ready_o`=1; 0 after a store.
- mem_ready_o  out  1  one-cycle data completion pulse.
- stall_o  out  1  pipeline stall request (combinational).
- bus_ce_o  out  1  external bus chip enable.
- bus_we_o  out  1  external write enable.
- bus_addr_o  out  32  external address.
- bus_sel_o  out  4  external byte enables.
- bus_data_o  out  32  external write data.
- bus_data_i  in  32  external read data.

## Operation
- FSM states: IDLE, DATA_ACC, INST_ACC.
- IDLE: a requester is eligible if its `ce_i`=1 and its own `ready_o` is not asserted in this cycle. The `ready_o` mask blocks re-granting a stale request.
- Fixed priority: data over instruction.
- On grant:
  - Latch address, we, sel and store data into bus registers (we=0, sel=4'b1111 for fetch).
  - Load the wait counter with WAIT_CYCLES-1.
  - Enter DATA_ACC or INST_ACC.
- ACC states:
  - Drive `bus_ce_o`=1 and the latched values. Requester input changes have no effect.
  - Decrement the counter each cycle.
  - At counter=0 the edge captures `bus_data_i` (loads/fetches), or 0 for stores, into the granted port's data register.
  - The same edge sets that port's `ready_o` for exactly one cycle and returns to IDLE.
- IDLE drives `bus_ce_o`=0, `bus_we_o`=0, and `bus_addr_o`/`bus_sel_o`/`bus_data_o`=0.
- `if_data_o`/`mem_data_o` hold their last captured value until the next completion on that port.
- stall_o = (if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o).
- Request withdrawn mid-access: the access completes normally, `ready_o` still pulses, and no retry occurs.
- Simultaneous requests in IDLE: data is granted. Fetch is granted on the next eligible IDLE cycle.
- In an IDLE cycle where one port's `ready_o`=1, the other port may be granted in that same cycle.

## Timing
- Reset (async assert): state IDLE, counter 0, and every output register 0. This gives `bus_*`=0, both `ready_o`=0, both `data_o`=0, and `stall_o` following inputs only.
  - An in-flight access is abandoned; `bus_ce_o` drops immediately on assertion.
  - No ready pulse is produced for an abandoned access.
- Latency, with the request first seen in IDLE at cycle 0:
  - `bus_ce_o` is high in cycles 1..WAIT_CYCLES.
  - `ready_o` is high in cycle WAIT_CYCLES+1.
- Same-port back-to-back throughput: one access per WAIT_CYCLES+2 cycles (ready cycle masked, new request granted the following cycle).
- Bus signals are registered and stable for the whole access; there is no glitching between accesses.
- WAIT_CYCLES=1: a single-cycle bus phase, and the counter starts at 0.

## Test plan
- Single fetch, WAIT_CYCLES=2, if_addr 0x00000100, bus_data_i 0x3C010001 → bus_ce_o=1 with addr 0x100 and we=0 in cycles 1-2; if_ready_o=1 with if_data_o=0x3C010001 in cycle 3; stall_o=1 in cycles 0-2 and 0 in cycle 3.
- Fetch 0x104 and load 0x2000 both raised in cycle 0 → load on bus cycles 1-2 and mem_ready_o in cycle 3; fetch on bus cycles 4-5 and if_ready_o in cycle 6.
- Store addr 0x2000, sel 4'b0011, data 0xDEADBEEF → bus_we_o=1, bus_sel_o=0011, bus_data_o=0xDEADBEEF for 2 cycles; mem_ready_o pulses with mem_data_o=0.
- Back-to-back fetches 0x100 then 0x104 with if_ce_i held high → exactly two accesses; the second bus_ce_o starts cycle 5; no duplicate access to 0x100.
- if_ce_i dropped in cycle 1 of a fetch → access runs to cycle 2; if_ready_o pulses in cycle 3; bus stays idle afterwards.
- rst pulled low in cycle 1 of a store with mem_ce_i still held → bus_ce_o=0 immediately and no mem_ready_o; after rst release the store restarts and completes WAIT_CYCLES+1 cycles later.
